// File: rtl/mix_pkg.sv
// mix_pkg: shared FSM state type and sample width for the voice mixer controller
package mix_pkg;
    localparam int SAMPLE_W = 8;
    typedef enum logic [2:0] {IDLE, ACCUM, START, WAIT, OUT} mix_state_t;
endpackage

// File: rtl/voice_mix_ctrl.sv
// voice_mix_ctrl: averages the active voices once per sample_tick using a shared sequential divider
// Ports: clk/rst (async active-high); sample_tick, voice_en, voice_sample in;
// div_start/div_dividend/div_divisor out and div_done/div_quo in (divider handshake);
// mix_out held result, mix_valid update pulse, overrun dropped-tick pulse.
module voice_mix_ctrl #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8,
    parameter int DIV_W      = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    output logic                           div_start,
    output logic [DIV_W-1:0]               div_dividend,
    output logic [DIV_W-1:0]               div_divisor,
    input  logic                           div_done,
    input  logic [7:0]                     div_quo,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_valid,
    output logic                           overrun
);
    import mix_pkg::*;
    localparam int CW = $clog2(NUM_VOICES + 1);
    localparam int AW = SAMPLE_W + CW;
    localparam int IW = $clog2(NUM_VOICES);
    mix_state_t                    state_q, state_d;
    logic [AW-1:0]                 acc_q, acc_d, acc_sum;
    logic [CW-1:0]                 cnt_q, cnt_d, cnt_sum;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [NUM_VOICES-1:0]         en_q, en_d;
    logic [NUM_VOICES*SAMPLE_W-1:0] smp_q, smp_d;
    logic                          div_start_q, div_start_d;
    logic [DIV_W-1:0]              dividend_q, dividend_d, divisor_q, divisor_d;
    logic [SAMPLE_W-1:0]           mix_out_q, mix_out_d;
    logic                          mix_valid_q, mix_valid_d, overrun_q, overrun_d;
    logic                          last_voice;
    // Running totals including the voice at idx, so the final count decides the path
    assign acc_sum    = acc_q + (en_q[idx_q] ? AW'(smp_q[idx_q*SAMPLE_W +: SAMPLE_W]) : AW'(0));
    assign cnt_sum    = cnt_q + CW'(en_q[idx_q]);
    assign last_voice = idx_q == IW'(NUM_VOICES - 1);
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        en_d        = en_q;
        smp_d       = smp_q;
        div_start_d = 1'b0;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = sample_tick && state_q != IDLE;
        case (state_q)
            IDLE: if (sample_tick) begin
                en_d    = voice_en;
                smp_d   = voice_sample;
                acc_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d = acc_sum;
                cnt_d = cnt_sum;
                idx_d = idx_q + IW'(1);
                if (last_voice) begin
                    // Operands are registered on entry so they are already valid during START
                    state_d     = cnt_sum >= CW'(2) ? START : OUT;
                    div_start_d = cnt_sum >= CW'(2);
                    dividend_d  = cnt_sum >= CW'(2) ? DIV_W'(acc_sum) : dividend_q;
                    divisor_d   = cnt_sum >= CW'(2) ? DIV_W'(cnt_sum) : divisor_q;
                end
            end
            START: state_d = WAIT;
            WAIT: if (div_done) begin
                mix_out_d   = div_quo;
                mix_valid_d = 1'b1;
                state_d     = IDLE;
            end
            OUT: begin
                mix_out_d   = cnt_q == '0 ? '0 : acc_q[SAMPLE_W-1:0];
                mix_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            en_q        <= '0;
            smp_q       <= '0;
            div_start_q <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            smp_q       <= smp_d;
            div_start_q <= div_start_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end
    assign div_start    = div_start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign mix_out      = mix_out_q;
    assign mix_valid    = mix_valid_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_voice_mix_ctrl.sv
// tb_voice_mix_ctrl: vector table, hand sequences and random transactions against a reference model
module tb_voice_mix_ctrl;
    logic        clk, rst, sample_tick, div_start, div_done, mix_valid, overrun;
    logic [3:0]  voice_en;
    logic [31:0] voice_sample;
    logic [23:0] div_dividend, div_divisor;
    logic [7:0]  div_quo, mix_out, model_quo;
    logic        model_done, inj_done;
    int          cyc, due, tests, fails;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] smp;
        int start_lat, dvd, dvs, valid_lat, out, xtick, novr;
    } vec_t;

    voice_mix_ctrl #(.NUM_VOICES(4), .SAMPLE_W(8), .DIV_W(24)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_en(voice_en),
        .voice_sample(voice_sample), .div_start(div_start), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_done(div_done), .div_quo(div_quo),
        .mix_out(mix_out), .mix_valid(mix_valid), .overrun(overrun)
    );

    assign div_done = model_done | inj_done;
    assign div_quo  = model_quo;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: done pulses 25 cycles after start, independent of controller reset
    initial begin
        model_done = 1'b0;
        model_quo  = '0;
        due        = -1;
        forever begin
            @(negedge clk);
            if (div_start === 1'b1 && div_divisor != 0) begin
                due       = cyc + 25;
                model_quo = 8'(div_dividend / div_divisor);
            end
            model_done = cyc == due;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t ref_vec(input logic [3:0] en, input logic [31:0] smp);
        vec_t r;
        int n = 0;
        int s = 0;
        for (int i = 0; i < 4; i++) if (en[i]) begin n++; s += int'(smp[i*8 +: 8]); end
        r.en = en; r.smp = smp; r.xtick = 0; r.novr = 0;
        if (n >= 2) begin
            r.start_lat = 5; r.dvd = s; r.dvs = n; r.valid_lat = 31; r.out = s / n;
        end else begin
            r.start_lat = -1; r.dvd = 0; r.dvs = 0; r.valid_lat = 6; r.out = (n == 0) ? 0 : s;
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        int t, nstart, nvalid, novr, slat, vlat, olat, dvd, dvs, outv;
        nstart = 0; nvalid = 0; novr = 0; slat = -1; vlat = -1; olat = -1; dvd = -1; dvs = -1; outv = -1;
        @(posedge clk); #1;
        voice_en = v.en; voice_sample = v.smp; sample_tick = 1'b1; t = cyc;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            sample_tick = (k == v.xtick);
            if (k == 1) begin voice_en = 4'($urandom); voice_sample = $urandom; end
            @(negedge clk);
            if (div_start) begin nstart++; slat = cyc - t; dvd = int'(div_dividend); dvs = int'(div_divisor); end
            if (mix_valid) begin nvalid++; vlat = cyc - t; outv = int'(mix_out); end
            if (overrun) begin novr++; olat = cyc - t; end
        end
        chk({name, " start_cnt"}, nstart, v.start_lat < 0 ? 0 : 1);
        if (v.start_lat >= 0) begin
            chk({name, " start_lat"}, slat, v.start_lat);
            chk({name, " dividend"}, dvd, v.dvd);
            chk({name, " divisor"}, dvs, v.dvs);
        end
        chk({name, " valid_cnt"}, nvalid, 1);
        chk({name, " valid_lat"}, vlat, v.valid_lat);
        chk({name, " mix_out"}, outv, v.out);
        chk({name, " mix_out_hold"}, int'(mix_out), v.out);
        chk({name, " overrun_cnt"}, novr, v.novr);
        if (v.novr > 0) chk({name, " overrun_lat"}, olat, v.xtick + 1);
    endtask

    vec_t vecs[11];

    initial begin
        int t, nact, nvalid, nstale;
        tests = 0; fails = 0; cyc = 0;
        vecs[0]  = '{4'b1111, 32'h281E140A, 5, 100, 4, 31, 25, 0, 0};
        vecs[1]  = '{4'b0010, 32'h0000C800, -1, 0, 0, 6, 200, 0, 0};
        vecs[2]  = '{4'b0000, 32'hFFFFFFFF, -1, 0, 0, 6, 0, 0, 0};
        vecs[3]  = '{4'b1111, 32'hFFFFFFFF, 5, 1020, 4, 31, 255, 0, 0};
        vecs[4]  = '{4'b0011, 32'hABCD01FF, 5, 256, 2, 31, 128, 0, 0};
        vecs[5]  = '{4'b0101, 32'h99047703, 5, 7, 2, 31, 3, 0, 0};
        vecs[6]  = '{4'b1000, 32'h4D112233, -1, 0, 0, 6, 77, 0, 0};
        vecs[7]  = '{4'b1111, 32'h281E140A, 5, 100, 4, 31, 25, 10, 1};
        vecs[8]  = '{4'b1111, 32'h281E140A, 5, 100, 4, 31, 25, 30, 1};
        vecs[9]  = '{4'b0011, 32'hABCD01FF, 5, 256, 2, 31, 128, 2, 1};
        vecs[10] = '{4'b0010, 32'h0000C800, -1, 0, 0, 6, 200, 5, 1};

        rst = 1'b1; inj_done = 1'b0; sample_tick = 1'b0; voice_en = '0; voice_sample = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            sample_tick = 1'($urandom); voice_en = 4'($urandom); voice_sample = $urandom; inj_done = 1'($urandom);
            @(negedge clk);
            chk("reset mix_out", int'(mix_out), 0);
            chk("reset mix_valid", int'(mix_valid), 0);
            chk("reset div_start", int'(div_start), 0);
            chk("reset dividend", int'(div_dividend), 0);
            chk("reset divisor", int'(div_divisor), 0);
            chk("reset overrun", int'(overrun), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; sample_tick = 1'b0; inj_done = 1'b0;
        nact = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mix_valid || div_start || overrun || mix_out != 0) nact++;
        end
        chk("idle after reset activity", nact, 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while the divide is in flight; its late completion must be ignored
        @(posedge clk); #1;
        voice_en = 4'b1111; voice_sample = 32'h281E140A; sample_tick = 1'b1; t = cyc;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        while (cyc < t + 10) begin @(posedge clk); #1; end
        chk("wait dividend before rst", int'(div_dividend), 100);
        rst = 1'b1; #1;
        chk("async rst mix_out", int'(mix_out), 0);
        chk("async rst dividend", int'(div_dividend), 0);
        chk("async rst divisor", int'(div_divisor), 0);
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b0;
        nvalid = 0; nstale = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mix_valid || div_start) nvalid++;
            if (div_done) nstale++;
        end
        chk("stale done seen", nstale, 1);
        chk("stale done activity", nvalid, 0);
        chk("stale done mix_out", int'(mix_out), 0);

        for (int i = 0; i < 20; i++) begin
            vec_t r;
            r = ref_vec(4'($urandom), $urandom);
            run_vec(r, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
